// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 16-bit GATE core: sequences fetch/decode/execute,
// waits on the memory ready handshake and stops the core on HALT, illegal opcodes or a hung access.
module multicycle_ctrl #(
    parameter int unsigned WAIT_MAX    = 15,
    parameter bit          RESET_PC_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] instruction,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        instrWrite,
    output logic        regWrite,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic [2:0]  ALUOp,
    output logic [1:0]  numBits,
    output logic        immShift,
    output logic        DOrS,
    output logic        memToReg,
    output logic        IorD,
    output logic        memRead,
    output logic        memWrite,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        branchNe,
    output logic [1:0]  PCSrc,
    output logic        halted,
    output logic [1:0]  err,
    output logic [3:0]  dbg_state_o
);

    // Handshake: the controller holds memRead/memWrite (and IorD) for every cycle it sits in
    // FETCH, MEM_RD or MEM_WR; a cycle with mem_ready=1 in one of those states completes the
    // access and the FSM advances on that edge. mem_ready in any other state is ignored.

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_STOP     = 4'd11
    } state_e;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_PASSB = 3'd4;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [1:0] err_q, err_d;
    logic       first_q, first_d;

    logic [3:0] opcode;
    logic       waiting;
    logic       timeout;
    logic       unused_inputs;

    assign opcode        = instruction[15:12];
    assign unused_inputs = ^{zero, instruction[11:0]};
    assign dbg_state_o   = state_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
            err_q   <= ERR_NONE;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        first_d = first_q;
        waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        // Ready on the last allowed cycle completes the access instead of timing out.
        timeout = waiting && !mem_ready && (wait_q == 8'(WAIT_MAX - 1));
        if (waiting) begin
            wait_d = mem_ready ? 8'd0 : wait_q + 8'd1;
        end
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                    first_d = 1'b0;
                end
            end
            S_DECODE: begin
                case (opcode)
                    4'h0, 4'h1, 4'h2, 4'h3: state_d = S_EXEC_R;
                    4'h4, 4'h5:             state_d = S_EXEC_I;
                    4'h6, 4'h7:             state_d = S_MEM_ADDR;
                    4'h8, 4'h9:             state_d = S_BRANCH;
                    4'hA:                   state_d = S_JUMP;
                    4'hF: begin
                        state_d = S_STOP;
                        err_d   = ERR_NONE;
                    end
                    default: begin
                        state_d = S_STOP;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_ALU_WB:           state_d = S_FETCH;
            S_MEM_ADDR:         state_d = (opcode == 4'h7) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:           if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:           state_d = S_FETCH;
            S_MEM_WR:           if (mem_ready) state_d = S_FETCH;
            S_BRANCH, S_JUMP:   state_d = S_FETCH;
            default:            state_d = S_STOP;
        endcase
        if (timeout) begin
            state_d = S_STOP;
            err_d   = ERR_TIMEOUT;
        end
        if ((state_d != state_q) &&
            ((state_d == S_FETCH) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR))) begin
            wait_d = 8'd0;
        end
    end

    always_comb begin
        instrWrite  = 1'b0;
        regWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 1'b0;
        ALUOp       = ALU_ADD;
        numBits     = 2'd0;
        immShift    = 1'b0;
        DOrS        = 1'b0;
        memToReg    = 1'b0;
        IorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        branchNe    = 1'b0;
        PCSrc       = 2'd0;
        halted      = 1'b0;
        err         = ERR_NONE;
        // Outputs are forced low while reset is held so nothing fires during an abort.
        if (RST_N) begin
            case (state_q)
                S_FETCH: begin
                    memRead    = 1'b1;
                    ALUSrcB    = 1'b1;
                    // IR and PC must load on the completing cycle itself.
                    instrWrite = mem_ready;
                    PCWrite    = mem_ready && (RESET_PC_EN || !first_q);
                end
                S_DECODE: begin
                    ALUSrcB = 1'b1;
                    numBits = 2'd1;
                end
                S_EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = {1'b0, opcode[1:0]};
                end
                S_EXEC_I: begin
                    ALUSrcA  = 1'b1;
                    ALUSrcB  = 1'b1;
                    numBits  = 2'd1;
                    immShift = (opcode == 4'h5);
                    ALUOp    = (opcode == 4'h5) ? ALU_PASSB : ALU_ADD;
                end
                S_ALU_WB: regWrite = 1'b1;
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 1'b1;
                end
                S_MEM_RD: begin
                    memRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    regWrite = 1'b1;
                    memToReg = 1'b1;
                end
                S_MEM_WR: begin
                    memWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSrc       = 2'd1;
                    branchNe    = (opcode == 4'h9);
                end
                S_JUMP: begin
                    PCWrite = 1'b1;
                    PCSrc   = 2'd2;
                end
                S_STOP: begin
                    halted = 1'b1;
                    err    = err_q;
                end
                default: halted = 1'b1;
            endcase
        end
    end

endmodule
